// File: rtl/pb_mop_pkg.sv
// rtl/pb_mop_pkg.sv - shared micro-op encodings and scheduler state type
package pb_mop_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_EXECUTE = 3'd4;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef enum logic {
        RUN     = 1'b0,
        QUIESCE = 1'b1
    } sched_st_t;

endpackage

// File: rtl/mop_sched_rr_pick.sv
// rtl/mop_sched_rr_pick.sv - circular first-one finder starting at a pointer
//
// Ports:
//   req     in  N      request vector
//   ptr     in  IDX_W  index where the circular search begins
//   gnt_idx out IDX_W  first requesting index at or after ptr (wrapping)
//   gnt_any out 1      at least one request present
module rr_pick #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[IDX_W'(j)]) begin
                gnt_idx = IDX_W'(j);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mop_sched.sv
// rtl/mop_sched.sv - round-robin micro-op scheduler with burst limit and quiesce
//
// Shares the matcher's single op input between N_SRC requesters through one
// registered output stage. NOPs are consumed and counted, never forwarded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   src_v/src_r              per-source valid/ready
//   src_opcode/side/price/qty packed per-source op fields
//   out_v/out_r              output handshake toward the matcher
//   out_opcode/side/price/qty/src  registered op fields and origin index
//   hold/hold_ack            quiesce request and drained acknowledge
//   ops_cnt/nop_cnt          free-running accepted-op and dropped-NOP counters
module mop_sched
    import pb_mop_pkg::*;
#(
    parameter int  PRICE_W = 48,
    parameter int  QTY_W   = 32,
    parameter int  N_SRC   = 2,
    parameter int  BURST   = 4,
    localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_v,
    output logic [N_SRC-1:0]         src_r,
    input  logic [N_SRC*3-1:0]       src_opcode,
    input  logic [N_SRC-1:0]         src_side,
    input  logic [N_SRC*PRICE_W-1:0] src_price,
    input  logic [N_SRC*QTY_W-1:0]   src_qty,
    output logic                     out_v,
    input  logic                     out_r,
    output logic [2:0]               out_opcode,
    output logic                     out_side,
    output logic [PRICE_W-1:0]       out_price,
    output logic [QTY_W-1:0]         out_qty,
    output logic [IDX_W-1:0]         out_src,
    input  logic                     hold,
    output logic                     hold_ack,
    output logic [N_SRC*32-1:0]      ops_cnt,
    output logic [31:0]              nop_cnt
);

    sched_st_t          st_q, st_d;
    logic               out_v_q, out_v_d;
    logic [2:0]         out_opcode_q, out_opcode_d;
    logic               out_side_q, out_side_d;
    logic [PRICE_W-1:0] out_price_q, out_price_d;
    logic [QTY_W-1:0]   out_qty_q, out_qty_d;
    logic [IDX_W-1:0]   out_src_q, out_src_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        ops_q [N_SRC];
    logic [31:0]        ops_d [N_SRC];
    logic [31:0]        nop_q, nop_d;

    logic [2:0]         op_a    [N_SRC];
    logic               side_a  [N_SRC];
    logic [PRICE_W-1:0] price_a [N_SRC];
    logic [QTY_W-1:0]   qty_a   [N_SRC];

    logic [IDX_W-1:0]   gnt_idx, nxt_idx;
    logic               gnt_any, load_ok, accept;

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        assign op_a[i]    = src_opcode[i*3 +: 3];
        assign side_a[i]  = src_side[i];
        assign price_a[i] = src_price[i*PRICE_W +: PRICE_W];
        assign qty_a[i]   = src_qty[i*QTY_W +: QTY_W];
        assign ops_cnt[i*32 +: 32] = ops_q[i];
    end

    rr_pick #(.N(N_SRC)) u_pick (
        .req     (src_v),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load_ok  = !out_v_q || out_r;
    assign accept   = gnt_any && load_ok && !hold;
    assign nxt_idx  = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
    assign hold_ack = (st_q == QUIESCE) && !out_v_q;

    assign out_v      = out_v_q;
    assign out_opcode = out_opcode_q;
    assign out_side   = out_side_q;
    assign out_price  = out_price_q;
    assign out_qty    = out_qty_q;
    assign out_src    = out_src_q;
    assign nop_cnt    = nop_q;

    // Ready is also masked by rst so sources see no handshake during reset.
    always_comb begin
        src_r = '0;
        if (accept && !rst) begin
            src_r[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            RUN:     if (hold)  st_d = QUIESCE;
            QUIESCE: if (!hold) st_d = RUN;
            default: st_d = RUN;
        endcase
    end

    always_comb begin
        out_v_d      = out_v_q;
        out_opcode_d = out_opcode_q;
        out_side_d   = out_side_q;
        out_price_d  = out_price_q;
        out_qty_d    = out_qty_q;
        out_src_d    = out_src_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        nop_d        = nop_q;
        for (int i = 0; i < N_SRC; i++) begin
            ops_d[i] = ops_q[i];
        end

        if (accept) begin
            if (op_a[gnt_idx] != OP_NOP) begin
                out_v_d          = 1'b1;
                out_opcode_d     = op_a[gnt_idx];
                out_side_d       = side_a[gnt_idx];
                out_price_d      = price_a[gnt_idx];
                out_qty_d        = qty_a[gnt_idx];
                out_src_d        = gnt_idx;
                ops_d[gnt_idx]   = ops_q[gnt_idx] + 32'd1;
            end else begin
                nop_d = nop_q + 32'd1;
                if (out_r) begin
                    out_v_d = 1'b0;
                end
            end

            // NOPs use a burst slot too, so a NOP flood cannot starve others.
            if ((gnt_idx != ptr_q && BURST == 1) ||
                (gnt_idx == ptr_q && cnt_q + 4'd1 == 4'(BURST))) begin
                ptr_d = nxt_idx;
                cnt_d = 4'd0;
            end else if (gnt_idx != ptr_q) begin
                ptr_d = gnt_idx;
                cnt_d = 4'd1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (out_r && out_v_q) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= RUN;
            out_v_q      <= 1'b0;
            out_opcode_q <= '0;
            out_side_q   <= 1'b0;
            out_price_q  <= '0;
            out_qty_q    <= '0;
            out_src_q    <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            nop_q        <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            st_q         <= st_d;
            out_v_q      <= out_v_d;
            out_opcode_q <= out_opcode_d;
            out_side_q   <= out_side_d;
            out_price_q  <= out_price_d;
            out_qty_q    <= out_qty_d;
            out_src_q    <= out_src_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            nop_q        <= nop_d;
            for (int i = 0; i < N_SRC; i++) begin
                ops_q[i] <= ops_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mop_sched.sv
// tb/tb_mop_sched.sv - self-checking bench for mop_sched
module tb_mop_sched;
    import pb_mop_pkg::*;

    localparam int PW = 48;
    localparam int QW = 32;
    localparam int NS = 2;
    localparam int BU = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   src_v, src_r, src_side;
    logic [NS*3-1:0] src_opcode;
    logic [NS*PW-1:0] src_price;
    logic [NS*QW-1:0] src_qty;
    logic            out_v, out_r, out_side, hold, hold_ack;
    logic [2:0]      out_opcode;
    logic [PW-1:0]   out_price;
    logic [QW-1:0]   out_qty;
    logic [0:0]      out_src;
    logic [NS*32-1:0] ops_cnt;
    logic [31:0]     nop_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mop_sched #(.PRICE_W(PW), .QTY_W(QW), .N_SRC(NS), .BURST(BU)) dut (
        .clk(clk), .rst(rst),
        .src_v(src_v), .src_r(src_r), .src_opcode(src_opcode), .src_side(src_side),
        .src_price(src_price), .src_qty(src_qty),
        .out_v(out_v), .out_r(out_r), .out_opcode(out_opcode), .out_side(out_side),
        .out_price(out_price), .out_qty(out_qty), .out_src(out_src),
        .hold(hold), .hold_ack(hold_ack), .ops_cnt(ops_cnt), .nop_cnt(nop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: which op sits in the output register, who owns the
    // current burst and how many of its slots are used, and whether quiesce is active.
    bit          m_ov, m_q;
    logic [2:0]  m_op;
    bit          m_side;
    logic [PW-1:0] m_price;
    logic [QW-1:0] m_qty;
    int          m_src, m_owner, m_used;
    logic [31:0] m_ops [NS];
    logic [31:0] m_nop;

    task automatic m_reset();
        m_ov = 0; m_q = 0; m_op = 0; m_side = 0; m_price = 0; m_qty = 0;
        m_src = 0; m_owner = 0; m_used = 0; m_nop = 0;
        for (int i = 0; i < NS; i++) m_ops[i] = 0;
    endtask

    function automatic int m_pick();
        int j;
        for (int k = 0; k < NS; k++) begin
            j = (m_owner + k) % NS;
            if (src_v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] m_ready();
        logic [NS-1:0] r;
        int g;
        r = '0;
        g = m_pick();
        if (g >= 0 && (!m_ov || out_r) && !hold && !rst) r[g] = 1'b1;
        return r;
    endfunction

    task automatic m_step();
        int g;
        bit acc;
        logic [2:0] op;
        g = m_pick();
        acc = (g >= 0) && (!m_ov || out_r) && !hold;
        if (acc) begin
            op = src_opcode[g*3 +: 3];
            if (op != OP_NOP) begin
                m_ov = 1; m_op = op; m_side = src_side[g];
                m_price = src_price[g*PW +: PW]; m_qty = src_qty[g*QW +: QW];
                m_src = g; m_ops[g] = m_ops[g] + 1;
            end else begin
                m_nop = m_nop + 1;
                if (out_r) m_ov = 0;
            end
            if (g == m_owner) begin
                m_used = m_used + 1;
                if (m_used == BU) begin m_owner = (g + 1) % NS; m_used = 0; end
            end else if (BU == 1) begin
                m_owner = (g + 1) % NS; m_used = 0;
            end else begin
                m_owner = g; m_used = 1;
            end
        end else if (out_r) begin
            m_ov = 0;
        end
        m_q = hold;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #2;
        check("src_r", src_r, m_ready());
        check("out_v", out_v, m_ov);
        check("hold_ack", hold_ack, m_q && !m_ov);
        check("nop_cnt", nop_cnt, m_nop);
        for (int k = 0; k < NS; k++) check("ops_cnt", ops_cnt[k*32 +: 32], m_ops[k]);
        if (m_ov) begin
            check("out_opcode", out_opcode, m_op);
            check("out_side", out_side, m_side);
            check("out_price", out_price, m_price);
            check("out_qty", out_qty, m_qty);
            check("out_src", out_src, m_src);
        end
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input bit v, input logic [2:0] op,
                           input logic [PW-1:0] price, input logic [QW-1:0] qty, input bit side);
        src_v[i] = v;
        src_opcode[i*3 +: 3] = op;
        src_price[i*PW +: PW] = price;
        src_qty[i*QW +: QW] = qty;
        src_side[i] = side;
    endtask

    task automatic do_reset();
        hold = 0; out_r = 1; src_v = '0;
        rst = 1; #1; m_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int r;
        logic [2:0] op;
        rst = 1; hold = 0; out_r = 1;
        src_v = '0; src_opcode = '0; src_side = '0; src_price = '0; src_qty = '0;
        m_reset();

        // Reset state, with requests present
        @(negedge clk);
        set_src(0, 1, OP_ADD, 48'd1, 32'd1, 0);
        set_src(1, 1, OP_ADD, 48'd2, 32'd2, 1);
        #1;
        check("rst_src_r", src_r, 0);
        check("rst_out_v", out_v, 0);
        check("rst_hold_ack", hold_ack, 0);
        check("rst_fields", {out_opcode, out_side, out_src}, 0);
        check("rst_price", out_price, 0);
        check("rst_qty", out_qty, 0);
        check("rst_ops", ops_cnt, 0);
        check("rst_nop", nop_cnt, 0);
        @(negedge clk);
        rst = 0; src_v = '0;

        // Single source stream
        for (int k = 0; k < 6; k++) begin
            set_src(0, 1, OP_ADD, PW'(100 + k), 32'd5, 0);
            set_src(1, 0, OP_ADD, 48'd0, 32'd0, 0);
            tick();
            check("single_price", out_price, 100 + k);
            check("single_src", out_src, 0);
        end
        check("single_ops", ops_cnt[31:0], 6);

        // Burst fairness
        do_reset();
        set_src(0, 1, OP_ADD, 48'd10, 32'd1, 0);
        set_src(1, 1, OP_ADD, 48'd20, 32'd2, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("fair_src", out_src, (k / 4) % 2);
        end

        // Backpressure
        do_reset();
        set_src(0, 1, OP_ADD, 48'd200, 32'd3, 0);
        set_src(1, 0, OP_ADD, 48'd0, 32'd0, 0);
        tick();
        out_r = 0;
        set_src(0, 1, OP_ADD, 48'd300, 32'd3, 0);
        set_src(1, 1, OP_ADD, 48'd400, 32'd4, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_src_r", src_r, 0);
            tick();
            check("bp_price", out_price, 200);
            check("bp_out_v", out_v, 1);
        end
        out_r = 1;
        tick();
        check("bp_resume", out_price, 300);

        // NOP drop takes one burst slot
        do_reset();
        set_src(0, 0, OP_ADD, 48'd0, 32'd0, 0);
        set_src(1, 1, OP_NOP, 48'd55, 32'd55, 1);
        tick();
        check("nop_out_v", out_v, 0);
        check("nop_cnt1", nop_cnt, 1);
        set_src(0, 1, OP_ADD, 48'd60, 32'd9, 0);
        set_src(1, 1, OP_ADD, 48'd70, 32'd7, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) check("nop_qty", out_qty, 7);
            check("nop_burst_src", out_src, (k < 3) ? 1 : 0);
        end
        check("nop_cnt_final", nop_cnt, 1);

        // Quiesce with a pending op
        do_reset();
        set_src(0, 1, OP_ADD, 48'd80, 32'd8, 0);
        set_src(1, 0, OP_ADD, 48'd0, 32'd0, 0);
        tick();
        src_v = '0; hold = 1; out_r = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("q_ack_low", hold_ack, 0);
        end
        out_r = 1;
        tick();
        check("q_ack_high", hold_ack, 1);
        hold = 0;
        set_src(0, 1, OP_ADD, 48'd81, 32'd8, 0);
        #1;
        check("q_release_src_r", src_r, 2'b01);
        check("q_ack_still", hold_ack, 1);
        tick();
        check("q_ack_fall", hold_ack, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NS; i++) begin
                r = $urandom_range(0, 9);
                op = (r < 2) ? OP_NOP : (r < 6) ? OP_ADD : 3'($urandom_range(1, 7));
                set_src(i, $urandom_range(0, 9) < 7, op, PW'({$urandom, $urandom}),
                        QW'($urandom), 1'($urandom_range(0, 1)));
            end
            out_r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            tick();
        end

        // Reset mid-stream
        hold = 0; out_r = 1;
        set_src(0, 1, OP_ADD, 48'd90, 32'd9, 0);
        set_src(1, 0, OP_ADD, 48'd0, 32'd0, 0);
        tick();
        check("mid_out_v_before", out_v, 1);
        set_src(1, 1, OP_ADD, 48'd91, 32'd9, 1);
        out_r = 0;
        #2;
        rst = 1;
        #1;
        check("mid_out_v", out_v, 0);
        check("mid_src_r", src_r, 0);
        check("mid_ops", ops_cnt, 0);
        check("mid_nop", nop_cnt, 0);
        m_reset();
        @(negedge clk);
        rst = 0; out_r = 1;
        #1;
        check("mid_first_grant", src_r, 2'b01);
        for (int k = 0; k < 4; k++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mop_sched.md
# mop_sched

Round-robin scheduler that shares the single micro-op input of the matching stage between `N_SRC` upstream requesters, such as the ITCH-resolved feed and local order entry. It issues one op per cycle through a registered output stage, bounds each requester's burst, and drops NOPs. A hold/ack quiesce handshake drains the matcher input path so the book can be reconfigured safely.

## Interface
Parameters:
- `PRICE_W`, 48, price width
- `QTY_W`, 32, quantity width
- `N_SRC`, 2, number of requesters (2..8)
- `BURST`, 4, maximum consecutive accepted ops per requester before the pointer rotates (1..15)

Ports:
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `src_v`  in  N_SRC  per-source valid
- `src_r`  out  N_SRC  per-source ready
- `src_opcode`  in  N_SRC*3  packed; source i at [i*3 +: 3]
- `src_side`  in  N_SRC  0 = bid, 1 = ask
- `src_price`  in  N_SRC*PRICE_W  packed
- `src_qty`  in  N_SRC*QTY_W  packed
- `out_v`  out  1  op valid toward matcher
- `out_r`  in  1  matcher ready
- `out_opcode`, `out_side`, `out_price`, `out_qty`  out  3/1/PRICE_W/QTY_W  registered op fields
- `out_src`  out  $clog2(N_SRC) (min 1)  index of the originating source
- `hold`  in  1  request quiesce; blocks new acceptance
- `hold_ack`  out  1  hold active and output stage empty
- `ops_cnt`  out  N_SRC*32  per-source count of accepted non-NOP ops; wraps at 2^32
- `nop_cnt`  out  32  count of accepted-and-dropped NOPs; wraps

## Operation
- Output stage is one register: `out_v_q` plus fields. `load_ok = !out_v_q || out_r`.
- Grant: the first `i` with `src_v[i]=1`, searching circularly from `ptr_q`. `src_r[g] = load_ok && !hold && !rst`. All other `src_r` are 0.
- Accept: `src_v[g] && src_r[g]`.
  - If the accepted opcode is not 0 (NOP), fields load into the output register and `out_src <= g`.
  - If the opcode is 0, it is consumed. `nop_cnt` increments. If `out_r` was high, `out_v_q` clears.
  - No accept and `out_r && out_v_q`: `out_v_q <= 0`.
- Burst pointer (`ptr_q`, `cnt_q` 4-bit), updated on every accept, NOPs included:
  - `g != ptr_q`: `ptr_q <= g`, `cnt_q <= 1`, except when `BURST == 1`, which rotates as below.
  - `g == ptr_q` and `cnt_q + 1 == BURST`: `ptr_q <= (g+1) mod N_SRC`, `cnt_q <= 0`.
  - Otherwise `cnt_q <= cnt_q + 1`.
  - A lone requester is re-granted after rotation; throughput is unaffected.
- Modes (2-state FSM):
  - RUN: normal arbitration.
  - QUIESCE: entered when `hold=1` and exited when `hold=0`.
  - The output register drains in QUIESCE. `hold_ack = (st==QUIESCE) && !out_v_q`, combinational from registered state.
  - `ptr_q`/`cnt_q` hold their values in QUIESCE.
- Output fields hold their value while `out_v_q && !out_r`. This is AXI-style stability: `out_v` never drops without `out_r`.
- Counters are free-running and wrap to 0 with no saturation.

## Timing
- Reset values: `out_v` 0, all `out_*` fields 0, `src_r` 0, `hold_ack` 0, all counters 0, `ptr_q` 0, `cnt_q` 0, state RUN.
- Latency: accepted op appears on `out_v` the next cycle. Throughput is one op per cycle with `out_r` held high.
- Backpressure: with `out_r=0` and `out_v=1`, all `src_r` are 0 in the same cycle.
- `hold` asserted in cycle t: no accept in t (`src_r` is 0 combinationally).
  - `hold_ack` rises the first cycle after FSM entry in which `out_v_q=0`.
  - With an empty output stage, `hold_ack` is high at t+1.
- `hold` deasserted: `src_r` may assert in the same cycle; `hold_ack` falls the next cycle.
- Reset asserted mid-transfer: the held op is discarded and `out_v` goes to 0 immediately (asynchronous). Sources must retry.
- `src_v` may drop without a handshake; the scheduler takes no action and keeps no memory of it.

## Structure
- Shared package `pb_mop_pkg`:
  - `OP_NOP=3'd0`, `OP_ADD=3'd1`, `OP_EXECUTE=3'd4`, and the side encoding `SIDE_BID=0`, `SIDE_ASK=1`.
  - The FSM enum `sched_st_t {RUN, QUIESCE}`.
- Sub-module `rr_pick`: combinational circular first-one finder (`req[N]`, `ptr`, returns `gnt_idx`, `gnt_any`), parameterized by `N`.

## Test plan
- Single source: N_SRC=2, BURST=4; src0 streams 6 ADDs price 100..105, `out_r=1`.
  - Required: `out` shows 100..105 on consecutive cycles one cycle after each accept, `out_src=0`, `ops_cnt[0]=6`.
- Burst fairness: both sources continuously valid.
  - Required: accept order is src0×4, src1×4, src0×4, …; no source waits more than 4 accepts.
- Backpressure: `out_r=0` for 5 cycles with `out_v=1`, price 200.
  - Required: `out_price` stays 200, `src_r` is 0 throughout, resume on `out_r=1` with no loss or duplication.
- NOP drop: src1 sends opcode 0 then ADD qty 7.
  - Required: `nop_cnt=1`, only the ADD appears on `out`, and the NOP consumes one burst slot.
- Quiesce: `hold=1` while one op is pending with `out_r=0`.
  - Required: `hold_ack` stays 0. After `out_r` pulses, `hold_ack=1` the next cycle. Releasing `hold` re-enables `src_r` in the same cycle.
- Reset mid-stream: assert `rst` while `out_v=1`.
  - Required: `out_v`, counters, and `src_r` are 0 asynchronously. After release, the first grant goes to src0.
